// File: rtl/c2_stream_ctrl_pkg.sv
// Shared definitions for the c2 stream controller: FSM encoding, default width
// and a constant-evaluable ceil(log2) helper.
package c2_stream_ctrl_pkg;

    localparam int DEFAULT_DATAWIDTH = 32;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result++;
            v = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/c2_stream_ctrl_if.sv
// Operand, datapath and result buses of the c2 stream controller.
// The controller uses the slave view; producer, datapath and consumer the master view.
interface c2_stream_ctrl_if
    import c2_stream_ctrl_pkg::*;
#(
    parameter int DATAWIDTH = DEFAULT_DATAWIDTH
);
    logic                        in_valid;
    logic                        in_ready;
    logic signed [DATAWIDTH-1:0] in_a;
    logic signed [DATAWIDTH-1:0] in_b;
    logic signed [DATAWIDTH-1:0] in_c;

    logic signed [DATAWIDTH-1:0] dp_a;
    logic signed [DATAWIDTH-1:0] dp_b;
    logic signed [DATAWIDTH-1:0] dp_c;
    logic signed [DATAWIDTH-1:0] dp_z;
    logic signed [DATAWIDTH-1:0] dp_x;

    logic                        out_valid;
    logic                        out_ready;
    logic signed [DATAWIDTH-1:0] out_z;
    logic signed [DATAWIDTH-1:0] out_x;

    modport slave (
        input  in_valid, in_a, in_b, in_c, dp_z, dp_x, out_ready,
        output in_ready, dp_a, dp_b, dp_c, out_valid, out_z, out_x
    );

    modport master (
        output in_valid, in_a, in_b, in_c, dp_z, dp_x, out_ready,
        input  in_ready, dp_a, dp_b, dp_c, out_valid, out_z, out_x
    );

endinterface

// File: rtl/c2_operand_fifo.sv
// Operand-triple FIFO: DEPTH entries of 3*DATAWIDTH bits, power-of-two depth so
// the pointers wrap by plain overflow.
module c2_operand_fifo
    import c2_stream_ctrl_pkg::*;
#(
    parameter int DATAWIDTH = DEFAULT_DATAWIDTH,
    parameter int DEPTH     = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [3*DATAWIDTH-1:0]   wr_data,
    output logic [3*DATAWIDTH-1:0]   head,
    output logic                     full,
    output logic                     empty,
    output logic [clog2(DEPTH):0]    count
);
    localparam int AW = clog2(DEPTH);

    logic [3*DATAWIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;
    logic                   do_push;
    logic                   do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // NOTE: storage has no reset; count and the pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/c2_stream_ctrl.sv
// Drives operand triples into a registered c2 datapath one at a time, waits out
// its latency and hands the captured z/x results downstream.
module c2_stream_ctrl
    import c2_stream_ctrl_pkg::*;
#(
    parameter int DATAWIDTH = DEFAULT_DATAWIDTH,
    parameter int DEPTH     = 4,
    parameter int LATENCY   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    c2_stream_ctrl_if.slave       bus,
    output logic                  busy,
    output logic [clog2(DEPTH):0] count
);
    localparam int CW = (clog2(LATENCY + 1) < 1) ? 1 : clog2(LATENCY + 1);

    logic [1:0]             state;
    logic [CW-1:0]          wait_cnt;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   pop;
    logic [3*DATAWIDTH-1:0] head;

    c2_operand_fifo #(
        .DATAWIDTH (DATAWIDTH),
        .DEPTH     (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (bus.in_valid && bus.in_ready),
        .pop     (pop),
        .wr_data ({bus.in_a, bus.in_b, bus.in_c}),
        .head    (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (count)
    );

    assign bus.in_ready = !fifo_full;

    // NOTE: default assignment first so no path through the case infers a latch.
    always_comb begin
        pop = 1'b0;
        case (state)
            ST_IDLE: pop = !fifo_empty;
            ST_HOLD: pop = bus.out_ready && !fifo_empty;
            default: pop = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= ST_IDLE;
            wait_cnt      <= '0;
            busy          <= 1'b0;
            bus.dp_a      <= '0;
            bus.dp_b      <= '0;
            bus.dp_c      <= '0;
            bus.out_z     <= '0;
            bus.out_x     <= '0;
            bus.out_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        {bus.dp_a, bus.dp_b, bus.dp_c} <= head;
                        wait_cnt <= CW'(LATENCY);
                        busy     <= 1'b1;
                        state    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt == '0) begin
                        bus.out_z     <= bus.dp_z;
                        bus.out_x     <= bus.dp_x;
                        bus.out_valid <= 1'b1;
                        state         <= ST_HOLD;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        // Back-to-back: the next triple issues on the accept edge.
                        if (pop) begin
                            {bus.dp_a, bus.dp_b, bus.dp_c} <= head;
                            wait_cnt <= CW'(LATENCY);
                            state    <= ST_WAIT;
                        end else begin
                            busy  <= 1'b0;
                            state <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_c2_stream_ctrl.sv
// Directed bench for c2_stream_ctrl with a registered datapath model
// z <= a + b, x <= a - c (one register stage).
module tb_c2_stream_ctrl;
    import c2_stream_ctrl_pkg::*;

    localparam int DW      = 32;
    localparam int DEPTH   = 4;
    localparam int LATENCY = 1;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       busy;
    logic [2:0] count;

    int checks   = 0;
    int errors   = 0;
    int cycle_no = 0;

    logic signed [DW-1:0] exp_z_q[$];
    logic signed [DW-1:0] exp_x_q[$];

    c2_stream_ctrl_if #(.DATAWIDTH(DW)) bus ();

    c2_stream_ctrl #(
        .DATAWIDTH (DW),
        .DEPTH     (DEPTH),
        .LATENCY   (LATENCY)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus),
        .busy  (busy),
        .count (count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle_no <= cycle_no + 1;

    always @(posedge clk) begin
        bus.dp_z <= bus.dp_a + bus.dp_b;
        bus.dp_x <= bus.dp_a - bus.dp_c;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic signed [DW-1:0] a, input logic signed [DW-1:0] b,
                            input logic signed [DW-1:0] c);
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_c     = c;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_valid(input int budget, input string tag);
        int n;
        n = 0;
        while (!bus.out_valid && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s_timeout: out_valid got %b expected 1 within %0d cycles", tag, bus.out_valid, budget);
        end
    endtask

    // Accepts n results (out_ready must be 1), checking order, occupancy and spacing.
    task automatic collect(input int n, input int first_count, input string tag);
        int got;
        int budget;
        int last_cycle;
        logic signed [DW-1:0] ez;
        logic signed [DW-1:0] ex;
        got        = 0;
        budget     = n * (LATENCY + 4) + 10;
        last_cycle = 0;
        while (got < n && budget > 0) begin
            if (bus.out_valid === 1'b1) begin
                ez = (exp_z_q.size() > 0) ? exp_z_q.pop_front() : '0;
                ex = (exp_x_q.size() > 0) ? exp_x_q.pop_front() : '0;
                checks++;
                if (bus.out_z !== ez) begin
                    errors++;
                    $display("FAIL %s_z[%0d]: got %0d expected %0d", tag, got, bus.out_z, ez);
                end
                checks++;
                if (bus.out_x !== ex) begin
                    errors++;
                    $display("FAIL %s_x[%0d]: got %0d expected %0d", tag, got, bus.out_x, ex);
                end
                checks++;
                if (count !== 3'(first_count - got)) begin
                    errors++;
                    $display("FAIL %s_count[%0d]: got %0d expected %0d", tag, got, count, first_count - got);
                end
                if (got > 0) begin
                    checks++;
                    if (cycle_no - last_cycle != LATENCY + 2) begin
                        errors++;
                        $display("FAIL %s_gap[%0d]: got %0d expected %0d", tag, got, cycle_no - last_cycle, LATENCY + 2);
                    end
                end
                last_cycle = cycle_no;
                got++;
            end
            tick();
            budget--;
        end
        checks++;
        if (got != n) begin
            errors++;
            $display("FAIL %s_results: got %0d expected %0d", tag, got, n);
        end
        checks++;
        if (busy !== 1'b0 || count !== 3'd0) begin
            errors++;
            $display("FAIL %s_drained: busy=%b count=%0d expected busy=0 count=0", tag, busy, count);
        end
    endtask

    task automatic test_reset();
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_c      = '0;
        bus.out_ready = 1'b1;
        rst           = 1'b0;
        #3;
        checks++;
        if (bus.in_ready !== 1'b1 || count !== 3'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: in_ready=%b count=%0d busy=%b expected 1/0/0", bus.in_ready, count, busy);
        end
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_z !== 0 || bus.out_x !== 0) begin
            errors++;
            $display("FAIL reset_out: valid=%b z=%0d x=%0d expected 0/0/0", bus.out_valid, bus.out_z, bus.out_x);
        end
        checks++;
        if (bus.dp_a !== 0 || bus.dp_b !== 0 || bus.dp_c !== 0) begin
            errors++;
            $display("FAIL reset_dp: dp=%0d/%0d/%0d expected 0/0/0", bus.dp_a, bus.dp_b, bus.dp_c);
        end
        tick();
        rst = 1'b1;
        tick();
        checks++;
        if (bus.in_ready !== 1'b1 || count !== 3'd0) begin
            errors++;
            $display("FAIL reset_release: in_ready=%b count=%0d expected 1/0", bus.in_ready, count);
        end
    endtask

    task automatic run_single(input logic signed [DW-1:0] a, input logic signed [DW-1:0] b,
                              input logic signed [DW-1:0] c, input logic signed [DW-1:0] ez,
                              input logic signed [DW-1:0] ex, input string tag);
        bus.out_ready = 1'b1;
        push_one(a, b, c);
        checks++;
        if (count !== 3'd1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_pushed: count=%0d busy=%b expected 1/0", tag, count, busy);
        end
        tick();
        checks++;
        if (bus.dp_a !== a || bus.dp_b !== b || bus.dp_c !== c) begin
            errors++;
            $display("FAIL %s_dp: got %0d/%0d/%0d expected %0d/%0d/%0d", tag, bus.dp_a, bus.dp_b, bus.dp_c, a, b, c);
        end
        checks++;
        if (busy !== 1'b1 || count !== 3'd0) begin
            errors++;
            $display("FAIL %s_issue: busy=%b count=%0d expected 1/0", tag, busy, count);
        end
        tick();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_early: out_valid got %b expected 0", tag, bus.out_valid);
        end
        tick();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_z !== ez || bus.out_x !== ex) begin
            errors++;
            $display("FAIL %s_result: valid=%b z=%0d x=%0d expected 1/%0d/%0d", tag, bus.out_valid, bus.out_z, bus.out_x, ez, ex);
        end
        tick();
        checks++;
        if (bus.out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_done: valid=%b busy=%b expected 0/0", tag, bus.out_valid, busy);
        end
    endtask

    task automatic test_basic();
        run_single(5, 3, 1, 8, 4, "basic");
    endtask

    task automatic test_signed();
        run_single(-7, 2, -10, -5, 3, "signed");
        checks++;
        if (bus.out_z !== 32'hFFFF_FFFB) begin
            errors++;
            $display("FAIL signed_raw: got %h expected fffffffb", bus.out_z);
        end
    endtask

    task automatic test_fill();
        bus.out_ready = 1'b0;
        push_one(10, 1, 1);
        push_one(20, 2, 2);
        push_one(30, 3, 3);
        push_one(40, 4, 4);
        push_one(50, 5, 5);
        checks++;
        if (count !== 3'd4 || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL fill_full: count=%0d in_ready=%b expected 4/0", count, bus.in_ready);
        end
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_z !== 11 || bus.out_x !== 9 || bus.dp_a !== 10) begin
            errors++;
            $display("FAIL fill_first: valid=%b z=%0d x=%0d dp_a=%0d expected 1/11/9/10", bus.out_valid, bus.out_z, bus.out_x, bus.dp_a);
        end
        bus.in_a     = 60;
        bus.in_b     = 6;
        bus.in_c     = 6;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_z !== 11 || bus.out_x !== 9 || count !== 3'd4) begin
                errors++;
                $display("FAIL fill_hold[%0d]: valid=%b z=%0d x=%0d count=%0d expected 1/11/9/4", i, bus.out_valid, bus.out_z, bus.out_x, count);
            end
        end
        bus.out_ready = 1'b1;
        tick();
        checks++;
        if (count !== 3'd3 || bus.dp_a !== 20 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL fill_refused: count=%0d dp_a=%0d valid=%b expected 3/20/0", count, bus.dp_a, bus.out_valid);
        end
        tick();
        bus.in_valid = 1'b0;
        checks++;
        if (count !== 3'd4) begin
            errors++;
            $display("FAIL fill_late_push: count=%0d expected 4", count);
        end
        exp_z_q = '{22, 33, 44, 55, 66};
        exp_x_q = '{18, 27, 36, 45, 54};
        collect(5, 4, "fill");
    endtask

    task automatic test_back_to_back();
        bus.out_ready = 1'b0;
        push_one(100, 1, 50);
        push_one(-20, -30, 5);
        push_one(7, 0, 7);
        push_one(0, -1, -1);
        wait_valid(8, "b2b");
        checks++;
        if (count !== 3'd3) begin
            errors++;
            $display("FAIL b2b_preload: count=%0d expected 3", count);
        end
        bus.out_ready = 1'b1;
        exp_z_q = '{101, -50, 7, -1};
        exp_x_q = '{50, -25, 0, 1};
        collect(4, 3, "b2b");
    endtask

    task automatic test_simul_push_pop();
        bus.out_ready = 1'b0;
        push_one(1, 1, 1);
        push_one(2, 3, 4);
        push_one(3, 3, 3);
        push_one(9, -4, 2);
        wait_valid(8, "simul");
        checks++;
        if (count !== 3'(DEPTH - 1) || bus.in_ready !== 1'b1 || bus.out_z !== 2 || bus.out_x !== 0) begin
            errors++;
            $display("FAIL simul_setup: count=%0d in_ready=%b z=%0d x=%0d expected 3/1/2/0", count, bus.in_ready, bus.out_z, bus.out_x);
        end
        bus.in_a      = -100;
        bus.in_b      = 50;
        bus.in_c      = -1;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        checks++;
        if (count !== 3'd3 || bus.dp_a !== 2 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL simul_edge: count=%0d dp_a=%0d valid=%b expected 3/2/0", count, bus.dp_a, bus.out_valid);
        end
        exp_z_q = '{5, 6, 5, -50};
        exp_x_q = '{-2, 0, 7, -99};
        collect(4, 3, "simul");
    endtask

    task automatic test_reset_mid();
        bus.out_ready = 1'b1;
        push_one(11, 22, 33);
        push_one(44, 55, 66);
        push_one(77, 88, 99);
        checks++;
        if (busy !== 1'b1 || count !== 3'd2 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_setup: busy=%b count=%0d valid=%b expected 1/2/0", busy, count, bus.out_valid);
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || busy !== 1'b0 || count !== 3'd0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_async: valid=%b busy=%b count=%0d in_ready=%b expected 0/0/0/1", bus.out_valid, busy, count, bus.in_ready);
        end
        checks++;
        if (bus.dp_a !== 0 || bus.out_z !== 0 || bus.out_x !== 0) begin
            errors++;
            $display("FAIL rstmid_data: dp_a=%0d z=%0d x=%0d expected 0/0/0", bus.dp_a, bus.out_z, bus.out_x);
        end
        tick();
        rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (bus.out_valid !== 1'b0 || busy !== 1'b0 || count !== 3'd0) begin
                errors++;
                $display("FAIL rstmid_after[%0d]: valid=%b busy=%b count=%0d expected 0/0/0", i, bus.out_valid, busy, count);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signed();
        test_fill();
        test_back_to_back();
        test_simul_push_pop();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
